// File: rtl/neuron_layer_sequencer.sv
// Fully connected layer sequencer: one neuron at a time on a shared MAC,
// followed by a registered thresholded-ReLU on each sum.
module neuron_layer_sequencer #(
  parameter int          N_IN   = 8,
  parameter int          N_NEU  = 4,
  parameter logic [14:0] THRESH = 15'h0100,
  localparam int IW = $clog2(N_IN),
  localparam int WW = $clog2(N_IN * N_NEU),
  localparam int NW = (N_NEU > 1) ? $clog2(N_NEU) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] in_addr,
  output logic [WW-1:0] w_addr,
  output logic          mac_clear,
  output logic          mac_en,
  input  logic [15:0]   mac_result,
  output logic [NW-1:0] out_addr,
  output logic [15:0]   out_data,
  output logic          out_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_DRAIN, S_RESULT, S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0] j_q, j_d;
  logic [NW-1:0] n_q, n_d;
  logic          busy_d, done_d, clr_d, en_d, ov_d;
  logic [NW-1:0] oa_d;
  logic [15:0]   od_d, act;
  logic          j_last, n_last;

  assign j_last = (j_q == IW'(N_IN - 1));
  assign n_last = (n_q == NW'(N_NEU - 1));

  assign in_addr = j_q;
  assign w_addr  = WW'(n_q) * WW'(N_IN) + WW'(j_q);

  // Negative sums and magnitudes at or below the threshold are squashed.
  assign act = (mac_result[15] || (mac_result[14:0] <= THRESH))
             ? 16'h0000 : mac_result;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = S_FETCH;
      S_FETCH:  if (j_last) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_RESULT;
      S_RESULT: state_d = n_last ? S_FIN : S_LOAD;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    j_d = j_q;
    n_d = n_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        j_d = '0;
        n_d = '0;
      end
      S_LOAD:   j_d = '0;
      S_FETCH:  if (!j_last) j_d = j_q + 1'b1;
      S_RESULT: if (!n_last) n_d = n_q + 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    clr_d  = (state_d == S_LOAD);
    // One cycle behind FETCH to line up with the memory read latency.
    en_d   = (state_q == S_FETCH);
    ov_d   = (state_q == S_RESULT);
    oa_d   = ov_d ? n_q : out_addr;
    od_d   = ov_d ? act : out_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      j_q       <= '0;
      n_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_clear <= 1'b0;
      mac_en    <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      j_q       <= j_d;
      n_q       <= n_d;
      busy      <= busy_d;
      done      <= done_d;
      mac_clear <= clr_d;
      mac_en    <= en_d;
      out_valid <= ov_d;
      out_addr  <= oa_d;
      out_data  <= od_d;
    end
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with a table-driven MAC model
// and hand-computed cycle positions for every strobe.
module tb_neuron_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, mac_clear, mac_en, out_valid;
  logic [2:0]  in_addr;
  logic [4:0]  w_addr;
  logic [1:0]  out_addr;
  logic [15:0] mac_result, out_data;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] tbl[4];
  logic [15:0] exp_data[4];
  int vcyc[8];
  int vaddr[8];
  logic [15:0] vdata[8];
  int ens[8];
  int nv, ndone, dcyc, ovl, clr_cnt, en_cnt;

  neuron_layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .in_addr(in_addr), .w_addr(w_addr),
    .mac_clear(mac_clear), .mac_en(mac_en),
    .mac_result(mac_result),
    .out_addr(out_addr), .out_data(out_data),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Caller sits at a negedge; the following posedge is edge 0.
  task automatic run(input int ncyc, input bit rep20, input bit hold,
                     input int rst_at);
    int p, k, idx;
    nv = 0; ndone = 0; dcyc = -1; ovl = 0; clr_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 8; i++) ens[i] = -1;
    mac_result = tbl[0];
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (out_valid && nv < 8) begin
        vcyc[nv] = c; vaddr[nv] = int'(out_addr); vdata[nv] = out_data;
        nv++;
      end
      if (done) begin
        ndone++; dcyc = c;
      end
      if (mac_clear && mac_en) ovl++;
      if (mac_clear) begin
        if (clr_cnt > 0 && clr_cnt <= 8) ens[clr_cnt-1] = en_cnt;
        clr_cnt++; en_cnt = 0;
      end
      if (mac_en) en_cnt++;
      p = (c - 1) % 11;
      k = (c - 1) / 11;
      if (c <= rst_at && c <= 44 && p >= 1 && p <= 8) begin
        check("w_addr", 32'(w_addr), 32'(k * 8 + p - 1));
        check("in_addr", 32'(in_addr), 32'(p - 1));
      end
      if (c == rst_at + 1) check("busy_after_rst", 32'(busy), 32'd0);
      if (hold && c == 47) begin
        check("reload_clear", 32'(mac_clear), 32'd1);
        check("reload_busy", 32'(busy), 32'd1);
      end
      idx = (clr_cnt == 0) ? 0 : ((clr_cnt > 4) ? 3 : clr_cnt - 1);
      mac_result = tbl[idx];
      start = (rep20 && c == 20) || (hold && c >= 45);
      rst = (c == rst_at);
    end
    if (clr_cnt > 0 && clr_cnt <= 8) ens[clr_cnt-1] = en_cnt;
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic verify(input int exp_nv, input int exp_done);
    check("nvalid", 32'(nv), 32'(exp_nv));
    for (int i = 0; i < nv && i < exp_nv; i++) begin
      check("valid_cyc", 32'(vcyc[i]), 32'((i + 1) * 11 + 1));
      check("out_addr", 32'(vaddr[i]), 32'(i));
      check("out_data", 32'(vdata[i]), 32'(exp_data[i]));
    end
    check("ndone", 32'(ndone), 32'(exp_done));
    if (exp_done != 0) begin
      check("done_cyc", 32'(dcyc), 32'd45);
      for (int i = 0; i < 4; i++) check("mac_en_cnt", 32'(ens[i]), 32'd8);
    end
    check("clr_en_overlap", 32'(ovl), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    mac_result = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outs",
            32'({busy, done, mac_clear, mac_en, out_valid,
                 in_addr, w_addr, out_addr, out_data}), 32'd0);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);

    // Full layer with start abuse: re-pulse at 20, held through FIN.
    for (int i = 0; i < 4; i++) begin
      tbl[i] = 16'h0500; exp_data[i] = 16'h0500;
    end
    run(48, 1'b1, 1'b1, 999);
    verify(4, 1);

    // Activation boundaries.
    tbl[0] = 16'h0100; exp_data[0] = 16'h0000;
    tbl[1] = 16'h0101; exp_data[1] = 16'h0101;
    tbl[2] = 16'h8500; exp_data[2] = 16'h0000;
    tbl[3] = 16'h0000; exp_data[3] = 16'h0000;
    run(46, 1'b0, 1'b0, 999);
    verify(4, 1);

    // Reset in the middle of neuron 1.
    for (int i = 0; i < 4; i++) begin
      tbl[i] = 16'h0500; exp_data[i] = 16'h0500;
    end
    run(46, 1'b0, 1'b0, 17);
    verify(1, 0);

    // Clean layer after the aborted one.
    tbl[2] = 16'h7fff; exp_data[2] = 16'h7fff;
    run(46, 1'b0, 1'b0, 999);
    verify(4, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
